// File: rtl/router_input_fifo.sv
// router_input_fifo
//   Per-port input buffer of the 5-port NoC router. Flits arrive over the
//   RTS/DCTS link handshake and are kept in a circular buffer. The head flit
//   goes to the crossbar and the routing logic. A grant from any output
//   arbiter pops the head flit.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   RX[DATA_WIDTH]      incoming flit from the upstream link
//   DRTS                upstream request-to-send, held high until CTS is seen
//   CTS                 registered one-cycle clear-to-send pulse to upstream
//   read_en_{N,E,W,S,L} grants from the output arbiters (pop requests)
//   Data_out            head flit, combinational from the read pointer
//   empty / full        occupancy is 0 / DEPTH
//   count[PTR_W+1]      current occupancy
//   err                 sticky protocol error: multi-grant or pop while empty
module router_input_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count,
  output logic                  err
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cts_state_e;

  cts_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  err_q, err_d;

  logic [4:0] grants;
  logic       rd_req;
  logic       multi_grant;
  logic       wr_fire;
  logic       rd_fire;

  assign grants = {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L};
  assign rd_req = |grants;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_grant = |(grants & (grants - 5'd1));

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));

  // Accept only while CTS is low, so a held DRTS yields one flit per pulse.
  assign wr_fire = DRTS & (state_q == IDLE) & ~full;
  assign rd_fire = rd_req & ~empty;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE:    if (wr_fire) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (wr_fire && !rd_fire)      count_d = count_q + (PTR_W+1)'(1);
    else if (rd_fire && !wr_fire) count_d = count_q - (PTR_W+1)'(1);

    if (multi_grant || (rd_req && empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= RX;
  end

  assign Data_out = mem[rd_ptr_q];
  assign CTS      = (state_q == ACK);
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_router_input_fifo.sv
module tb_router_input_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] RX;
  logic        DRTS;
  logic        CTS;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty, full;
  logic [2:0]  count;
  logic        err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  router_input_fifo #(
    .DATA_WIDTH(32),
    .DEPTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .DRTS     (DRTS),
    .CTS      (CTS),
    .read_en_N(read_en_N),
    .read_en_E(read_en_E),
    .read_en_W(read_en_W),
    .read_en_S(read_en_S),
    .read_en_L(read_en_L),
    .Data_out (Data_out),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    DRTS = 1'b0;
    RX   = '0;
    read_en_N = 1'b0; read_en_E = 1'b0; read_en_W = 1'b0;
    read_en_S = 1'b0; read_en_L = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Upstream side: hold DRTS with stable RX until CTS is seen, then drop it.
  task automatic send(input logic [31:0] data);
    int unsigned n;
    RX   = data;
    DRTS = 1'b1;
    n    = 0;
    do begin
      tick();
      n++;
    end while (!CTS && n < 20);
    check("send_cts", {31'd0, CTS}, 32'd1);
    DRTS = 1'b0;
  endtask

  // Check the head flit, then pop it with the East grant.
  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, Data_out, exp);
    read_en_E = 1'b1;
    tick();
    read_en_E = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cts",   {31'd0, CTS},   32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full},  32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    rst = 1'b1;

    // Single flit: accepted on the first edge, CTS is a one-cycle pulse.
    RX = 32'hA5A5_0001;
    DRTS = 1'b1;
    tick();
    check("s1_cts",   {31'd0, CTS},   32'd1);
    check("s1_count", {29'd0, count}, 32'd1);
    check("s1_empty", {31'd0, empty}, 32'd0);
    check("s1_data",  Data_out,       32'hA5A5_0001);
    DRTS = 1'b0;
    tick();
    check("s1_cts_drop", {31'd0, CTS},   32'd0);
    check("s1_count2",   {29'd0, count}, 32'd1);

    // Fill to full, then a fifth flit waits until a pop frees a slot.
    do_reset();
    for (int i = 1; i <= 4; i++) send(32'(i));
    tick();
    check("full_flag",  {31'd0, full},  32'd1);
    check("full_count", {29'd0, count}, 32'd4);
    RX = 32'd5;
    DRTS = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_cts_held", {31'd0, CTS},   32'd0);
      check("full_count_held", {29'd0, count}, 32'd4);
    end
    read_en_E = 1'b1;
    tick();
    read_en_E = 1'b0;
    check("full_pop_data",  Data_out,       32'd2);
    check("full_pop_count", {29'd0, count}, 32'd3);
    check("full_pop_cts",   {31'd0, CTS},   32'd0);
    tick();
    DRTS = 1'b0;
    check("full_f5_cts",   {31'd0, CTS},   32'd1);
    check("full_f5_count", {29'd0, count}, 32'd4);
    pop_check("drain_2", 32'd2);
    pop_check("drain_3", 32'd3);
    pop_check("drain_4", 32'd4);
    pop_check("drain_5", 32'd5);
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_err",   {31'd0, err},   32'd0);

    // Wrap-around: pointers pass DEPTH-1 -> 0 twice.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(32'h10 + 32'(i));
      check("wrap_data", Data_out, 32'h10 + 32'(i));
      read_en_L = 1'b1;
      tick();
      read_en_L = 1'b0;
    end
    check("wrap_empty", {31'd0, empty}, 32'd1);
    check("wrap_err",   {31'd0, err},   32'd0);

    // Simultaneous read and write at count=2.
    do_reset();
    send(32'h21);
    send(32'h22);
    RX = 32'h23;
    DRTS = 1'b1;
    tick();
    check("sim_pre_count", {29'd0, count}, 32'd2);
    check("sim_pre_cts",   {31'd0, CTS},   32'd0);
    read_en_W = 1'b1;
    tick();
    read_en_W = 1'b0;
    DRTS = 1'b0;
    check("sim_count", {29'd0, count}, 32'd2);
    check("sim_head",  Data_out,       32'h22);
    check("sim_cts",   {31'd0, CTS},   32'd1);
    pop_check("sim_d22", 32'h22);
    pop_check("sim_d23", 32'h23);
    check("sim_empty", {31'd0, empty}, 32'd1);

    // Pop while empty: error flag, pointers untouched.
    do_reset();
    read_en_N = 1'b1;
    tick();
    read_en_N = 1'b0;
    check("pe_err",   {31'd0, err},   32'd1);
    check("pe_count", {29'd0, count}, 32'd0);
    send(32'h31);
    check("pe_head",  Data_out,       32'h31);
    check("pe_count1", {29'd0, count}, 32'd1);

    // Multi-grant at count=3: error, single pop.
    do_reset();
    check("mg_err_clr", {31'd0, err}, 32'd0);
    send(32'h41);
    send(32'h42);
    send(32'h43);
    tick();
    read_en_N = 1'b1;
    read_en_S = 1'b1;
    tick();
    read_en_N = 1'b0;
    read_en_S = 1'b0;
    check("mg_err",   {31'd0, err},   32'd1);
    check("mg_count", {29'd0, count}, 32'd2);
    check("mg_head",  Data_out,       32'h42);

    // Asynchronous reset between edges with count=3, CTS=1, err=1.
    do_reset();
    read_en_N = 1'b1;
    tick();
    read_en_N = 1'b0;
    send(32'h51);
    send(32'h52);
    send(32'h53);
    check("ar_pre_count", {29'd0, count}, 32'd3);
    check("ar_pre_err",   {31'd0, err},   32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_cts",   {31'd0, CTS},   32'd0);
    check("ar_count", {29'd0, count}, 32'd0);
    check("ar_err",   {31'd0, err},   32'd0);
    check("ar_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_input_fifo.md
Name: router_input_fifo

Overview:
- Per-port input buffer of the 5-port NoC router. It sits directly upstream of the per-output arbiters.
- Accepts flits from the neighbouring router's output over the RTS/DCTS link handshake and stores them in a circular buffer.
- Presents the head flit to the crossbar and to routing logic.
- Pops the head flit when any downstream arbiter grants this port.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, number of flit slots; must be a power of two, at least 2.
- PTR_W, log2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- RX  in  DATA_WIDTH  incoming flit from the upstream link.
- DRTS  in  1  upstream request-to-send; held high until CTS is seen.
- CTS  out  1  clear-to-send back to upstream; registered one-cycle pulse.
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  in  1 each  grant from the arbiter of each output port; pop request.
- Data_out  out  DATA_WIDTH  head flit, combinational from the read pointer.
- empty  out  1  buffer holds 0 flits.
- full  out  1  buffer holds DEPTH flits.
- count  out  PTR_W+1  current occupancy.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - CTS=0, rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, err=0.
  - Storage contents are don't-care, so Data_out is X-tolerant.
  - Deassertion of rst is sampled synchronously. First accept is possible on the first edge with rst=1.
- Accept (write):
  - wr_fire = DRTS & ~CTS & ~full, evaluated before the edge.
  - On that edge: mem[wr_ptr] <= RX, wr_ptr increments modulo DEPTH, and CTS <= 1.
  - On the following edge CTS <= 0 unconditionally.
  - Result: CTS is exactly one cycle wide, with at most one accept per two cycles per link. This matches the upstream arbiter, which drops RTS on the edge where RTS & DCTS.
- Full: when full=1, DRTS is held off and CTS stays 0. No write occurs and no data is lost. Upstream keeps RX stable while DRTS=1.
- Pop (read):
  - rd_req = OR of the five read_en_* inputs.
  - rd_fire = rd_req & ~empty.
  - On that edge rd_ptr increments modulo DEPTH.
  - Data_out always equals mem[rd_ptr], so the next flit is visible in the cycle after the pop.
- Simultaneous events:
  - wr_fire and rd_fire in the same cycle: both pointers advance and count is unchanged.
  - full blocks the write even if a pop happens that cycle, because full is evaluated on current state. No same-cycle pass-through.
  - rd_req while empty: ignored, pointers unchanged.
- Occupancy:
  - count changes by +1 on write only and by -1 on read only.
  - empty = (count==0); full = (count==DEPTH). Both are derived from registered count, with no combinational path from inputs.
  - Pointer wrap: DEPTH-1 -> 0.
- err (sticky until reset) is set on the edge where either condition holds:
  - more than one read_en_* is high (multi-grant; the pop still advances once), or
  - rd_req is high while empty=1.
- Single clock domain; no internal state machine beyond the CTS pulse FSM:
  - IDLE(CTS=0) -> ACK(CTS=1) on wr_fire.
  - ACK -> IDLE always.
- Reset mid-operation: all pointers, count and CTS clear immediately (asynchronously). Buffered flits are discarded.

Test Plan:
- Reset then single flit: hold DRTS=1, RX=0xA5A5_0001 → CTS high for exactly one cycle on the next edge, count=1, empty=0, Data_out=0xA5A5_0001; DRTS dropped after CTS.
- Fill to full: four back-to-back handshakes with RX=1,2,3,4 and DRTS held for a fifth flit 5 → full=1, count=4, CTS stays 0 while full. Pulse read_en_E once → Data_out becomes 2, then flit 5 is accepted on the next free cycle.
- Wrap-around: 10 writes interleaved with 10 pops (read_en_L) using values 0x10..0x19 → Data_out sequence in order 0x10..0x19, empty=1 at end, err=0.
- Simultaneous read/write at count=2 → count stays 2; the head advances by one and the new flit is appended at the tail.
- Protocol errors: read_en_N=1 while empty → err=1, pointers unchanged. After reset, read_en_N=read_en_S=1 with count=3 → err=1, count=2.
- Async reset mid-transfer: assert rst=0 between clock edges with count=3 and CTS=1 → CTS, count and err are 0 and empty=1 immediately, without waiting for a clock edge.
